// File: rtl/sensor_pkg.sv
// Shared types and phase tables for the parking-lot car stimulus generator.
// Contents:
//   sim_state_t  - sequence FSM states (IDLE, PH1, PH2, PH3)
//   car_dir_t    - direction latched when a request is accepted
//   ENTER_SEQ    - {b,a} codes for PH1..PH3 of a car entering
//   EXIT_SEQ     - {b,a} codes for PH1..PH3 of a car leaving
//   phase_code() - {b,a} code for a given direction and state (IDLE -> 00)
package sensor_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, PH1 = 2'd1, PH2 = 2'd2, PH3 = 2'd3} sim_state_t;
  typedef enum logic {DIR_ENTER = 1'b0, DIR_EXIT = 1'b1} car_dir_t;

  localparam logic [1:0] ENTER_SEQ [3] = '{2'b01, 2'b11, 2'b10};
  localparam logic [1:0] EXIT_SEQ  [3] = '{2'b10, 2'b11, 2'b01};

  function automatic logic [1:0] phase_code(input car_dir_t dir, input sim_state_t state);
    logic [1:0] code;
    code = 2'b00;
    case (state)
      PH1:     code = (dir == DIR_ENTER) ? ENTER_SEQ[0] : EXIT_SEQ[0];
      PH2:     code = (dir == DIR_ENTER) ? ENTER_SEQ[1] : EXIT_SEQ[1];
      PH3:     code = (dir == DIR_ENTER) ? ENTER_SEQ[2] : EXIT_SEQ[2];
      default: code = 2'b00;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/car_sim_if.sv
// Request/sensor bundle between a requester and the car_sim generator.
// Signals:
//   start_enter, start_exit - requests (driven by the requester)
//   a, b                    - photo-sensor lines (1 = blocked)
//   ready                   - generator idle, request will be sampled
//   done                    - one-cycle pulse at the end of a sequence
//   reject                  - one-cycle pulse when a request is refused
//   occupancy               - cars currently in the lot
// Modports: master = requester side, slave = generator side.
interface car_sim_if #(
  parameter int CAPACITY = 16
) ();
  localparam int OCC_W = $clog2(CAPACITY + 1);

  logic             start_enter;
  logic             start_exit;
  logic             a;
  logic             b;
  logic             ready;
  logic             done;
  logic             reject;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output start_enter, start_exit,
    input  a, b, ready, done, reject, occupancy
  );

  modport slave (
    input  start_enter, start_exit,
    output a, b, ready, done, reject, occupancy
  );
endinterface

// File: rtl/phase_timer.sv
// Hold-time counter for one sensor phase.
// Ports:
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   clr     - restart the count at 0 on the next edge
//   expire  - high in the last cycle of a phase (count == HOLD_CYCLES-1)
// Parameter HOLD_CYCLES (>= 1): cycles per phase.
module phase_timer #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic expire
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (cnt == LAST);
endmodule

// File: rtl/car_sim.sv
// Parking-lot car stimulus generator: drives the two photo-sensor lines
// through a complete enter or exit blocking sequence on request.
// Ports:
//   clk     - system clock
//   reset_n - asynchronous active-low reset; aborts any sequence at once
//   bus     - car_sim_if.slave: start_enter/start_exit in; a, b, ready,
//             done, reject, occupancy out
// Parameters: HOLD_CYCLES (cycles per phase, >= 1), CAPACITY (lot size).
// Optional feature macro CAR_SIM_OCC_EN: occupancy tracking with refusal of
// enters into a full lot and exits from an empty lot. Without it reject and
// occupancy are held at 0.
module car_sim
  import sensor_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int CAPACITY    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  car_sim_if.slave    bus
);
  localparam int OCC_W = $clog2(CAPACITY + 1);

  sim_state_t       state, state_nx;
  car_dir_t         dir, dir_nx;
  logic [1:0]       ba_nx;
  logic             a_q, b_q, ready_q, done_q;
  logic             ready_nx, done_nx;
  logic             timer_clr, expire;
  logic             enter_ok, exit_ok;
  logic [OCC_W-1:0] occ;
  logic             reject_q;

  phase_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (timer_clr),
    .expire  (expire)
  );

  always_comb begin
    state_nx  = state;
    dir_nx    = dir;
    done_nx   = 1'b0;
    timer_clr = 1'b0;
    case (state)
      IDLE: begin
        // Counter held at 0 so PH1 starts a fresh hold interval.
        timer_clr = 1'b1;
        if (bus.start_enter) begin
          // Enter has priority; a refused enter does not fall through to exit.
          if (enter_ok) begin
            state_nx = PH1;
            dir_nx   = DIR_ENTER;
          end
        end else if (bus.start_exit && exit_ok) begin
          state_nx = PH1;
          dir_nx   = DIR_EXIT;
        end
      end
      PH1: begin
        if (expire) begin
          state_nx  = PH2;
          timer_clr = 1'b1;
        end
      end
      PH2: begin
        if (expire) begin
          state_nx  = PH3;
          timer_clr = 1'b1;
        end
      end
      PH3: begin
        if (expire) begin
          state_nx  = IDLE;
          done_nx   = 1'b1;
          timer_clr = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    ready_nx = (state_nx == IDLE);
    // Sensor lines come straight from flops, so each code change is clean.
    ba_nx    = phase_code(dir_nx, state_nx);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      dir     <= DIR_ENTER;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state      <= state_nx;
      dir        <= dir_nx;
      {b_q, a_q} <= ba_nx;
      ready_q    <= ready_nx;
      done_q     <= done_nx;
    end
  end

`ifdef CAR_SIM_OCC_EN
  logic reject_nx;

  assign enter_ok  = (occ != OCC_W'(CAPACITY));
  assign exit_ok   = (occ != '0);
  assign reject_nx = (state == IDLE) &&
                     (bus.start_enter ? !enter_ok : (bus.start_exit && !exit_ok));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ      <= '0;
      reject_q <= 1'b0;
    end else begin
      reject_q <= reject_nx;
      // Count changes on the same edge that raises done.
      if (done_nx) begin
        occ <= (dir == DIR_ENTER) ? occ + 1'b1 : occ - 1'b1;
      end
    end
  end
`else
  assign enter_ok = 1'b1;
  assign exit_ok  = 1'b1;
  assign occ      = '0;
  assign reject_q = 1'b0;
`endif

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.reject    = reject_q;
  assign bus.occupancy = occ;
endmodule

// File: tb/tb_car_sim.sv
module tb_car_sim;
  localparam int CAP = 2;
`ifdef CAR_SIM_OCC_EN
  localparam bit OCC_EN = 1'b1;
`else
  localparam bit OCC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  car_sim_if #(.CAPACITY(CAP)) bus0 ();
  car_sim_if #(.CAPACITY(CAP)) bus1 ();

  car_sim #(.HOLD_CYCLES(2), .CAPACITY(CAP)) u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0.slave)
  );

  car_sim #(.HOLD_CYCLES(1), .CAPACITY(CAP)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1.slave)
  );

  int total = 0;
  int bad = 0;
  bit run = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Flattened views of both instances.
  logic [1:0] dut_ab [2];
  logic       dut_rdy [2];
  logic       dut_done [2];
  logic       dut_rej [2];
  logic [31:0] dut_occ [2];
  assign dut_ab[0]   = {bus0.b, bus0.a};
  assign dut_ab[1]   = {bus1.b, bus1.a};
  assign dut_rdy[0]  = bus0.ready;
  assign dut_rdy[1]  = bus1.ready;
  assign dut_done[0] = bus0.done;
  assign dut_done[1] = bus1.done;
  assign dut_rej[0]  = bus0.reject;
  assign dut_rej[1]  = bus1.reject;
  assign dut_occ[0]  = 32'(bus0.occupancy);
  assign dut_occ[1]  = 32'(bus1.occupancy);

  // ---------------- behavioural model ----------------
  // A sequence is "busy" for 3*hold cycles after acceptance; the phase is
  // elapsed/hold, and the sensor code comes from the direction's phase list.
  int  hold [2] = '{2, 1};
  bit  busy [2];
  bit  mdir [2];      // 0 = enter, 1 = exit
  int  el [2];
  bit  m_done [2];
  bit  m_rej [2];
  int  m_occ [2];
  int  n_enter [2];
  int  n_exit [2];
  int  done_cnt [2];

  function automatic logic [1:0] seq_code(input bit d, input int ph);
    logic [1:0] c;
    c = 2'b00;
    case (ph)
      0: c = d ? 2'b10 : 2'b01;
      1: c = 2'b11;
      2: c = d ? 2'b01 : 2'b10;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        busy[i] = 1'b0; el[i] = 0; m_done[i] = 1'b0; m_rej[i] = 1'b0; m_occ[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit se, sx;
        se = (i == 0) ? bus0.start_enter : bus1.start_enter;
        sx = (i == 0) ? bus0.start_exit  : bus1.start_exit;
        m_done[i] = 1'b0;
        m_rej[i]  = 1'b0;
        if (busy[i]) begin
          el[i]++;
          if (el[i] == 3 * hold[i]) begin
            busy[i] = 1'b0;
            m_done[i] = 1'b1;
            if (mdir[i]) begin
              n_exit[i]++;
              if (OCC_EN) m_occ[i]--;
            end else begin
              n_enter[i]++;
              if (OCC_EN) m_occ[i]++;
            end
          end
        end else if (se) begin
          if (OCC_EN && m_occ[i] == CAP) m_rej[i] = 1'b1;
          else begin busy[i] = 1'b1; el[i] = 0; mdir[i] = 1'b0; end
        end else if (sx) begin
          if (OCC_EN && m_occ[i] == 0) m_rej[i] = 1'b1;
          else begin busy[i] = 1'b1; el[i] = 0; mdir[i] = 1'b1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < 2; i++) begin
        logic [1:0] e;
        e = busy[i] ? seq_code(mdir[i], el[i] / hold[i]) : 2'b00;
        check($sformatf("ab%0d", i), 32'(dut_ab[i]), 32'(e));
        check($sformatf("ready%0d", i), 32'(dut_rdy[i]), 32'(!busy[i]));
        check($sformatf("done%0d", i), 32'(dut_done[i]), 32'(m_done[i]));
        check($sformatf("reject%0d", i), 32'(dut_rej[i]), 32'(m_rej[i]));
        check($sformatf("occ%0d", i), dut_occ[i], 32'(m_occ[i]));
        if (dut_done[i] === 1'b1) done_cnt[i]++;
      end
    end
  end

  // ---------------- lot-side detector on instance 0 ----------------
  logic [1:0] prev_ab;
  logic [1:0] hist [3];
  int hlen = 0;
  int det_enter = 0;
  int det_exit = 0;
  int det_spur = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_ab = 2'b00;
      hlen = 0;
    end else begin
      logic [1:0] cur;
      cur = {bus0.b, bus0.a};
      if (cur != prev_ab) begin
        if (cur == 2'b00) begin
          if (hlen == 3 && hist[0] == 2'b01 && hist[1] == 2'b11 && hist[2] == 2'b10) det_enter++;
          else if (hlen == 3 && hist[0] == 2'b10 && hist[1] == 2'b11 && hist[2] == 2'b01) det_exit++;
          else det_spur++;
          hlen = 0;
        end else begin
          if (hlen < 3) hist[hlen] = cur;
          hlen++;
        end
      end
      prev_ab = cur;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int i, input bit en, input bit ex);
    if (i == 0) begin bus0.start_enter = en; bus0.start_exit = ex; end
    else begin bus1.start_enter = en; bus1.start_exit = ex; end
  endtask

  // Request held across exactly one posedge; returns on the following negedge.
  task automatic req(input int i, input bit en, input bit ex);
    @(negedge clk);
    drive(i, en, ex);
    @(negedge clk);
    drive(i, 1'b0, 1'b0);
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    while (dut_rdy[i] !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (dut_rdy[i] !== 1'b1) check("wait_ready_timeout", 32'(dut_rdy[i]), 32'd1);
  endtask

  logic [1:0] t1_ab [7];
  int d0;

  initial begin
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    t1_ab = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00};

    // Reset state
    #12;
    check("rst_a", 32'(bus0.a), 32'd0);
    check("rst_b", 32'(bus0.b), 32'd0);
    check("rst_ready", 32'(bus0.ready), 32'd1);
    check("rst_done", 32'(bus0.done), 32'd0);
    check("rst_reject", 32'(bus0.reject), 32'd0);
    check("rst_occ", 32'(bus0.occupancy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run = 1'b1;

`ifdef CAR_SIM_OCC_EN
    // Occupancy limits with CAPACITY=2
    req(0, 1'b0, 1'b1);
    check("t5_exit_empty_reject", 32'(bus0.reject), 32'd1);
    check("t5_exit_empty_ab", 32'(dut_ab[0]), 32'd0);
    for (int k = 1; k <= 2; k++) begin
      req(0, 1'b1, 1'b0);
      wait_ready(0);
      check("t5_occ_after_enter", 32'(bus0.occupancy), 32'(k));
      check("t5_done_enter", 32'(bus0.done), 32'd1);
    end
    req(0, 1'b1, 1'b0);
    check("t5_full_reject", 32'(bus0.reject), 32'd1);
    check("t5_full_ab", 32'(dut_ab[0]), 32'd0);
    check("t5_full_occ", 32'(bus0.occupancy), 32'd2);
    @(negedge clk);
    check("t5_reject_one_cycle", 32'(bus0.reject), 32'd0);
    for (int k = 0; k < 2; k++) begin
      req(0, 1'b0, 1'b1);
      wait_ready(0);
    end
    check("t5_occ_back_to_0", 32'(bus0.occupancy), 32'd0);
    // Instance 1 needs a car inside before its exit test.
    req(1, 1'b1, 1'b0);
    wait_ready(1);
`endif

    // Test 1: HOLD=2 enter sequence, literal waveform
    wait_ready(0);
    req(0, 1'b1, 1'b0);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("t1_ab_c%0d", c + 1), 32'(dut_ab[0]), 32'(t1_ab[c]));
      check($sformatf("t1_done_c%0d", c + 1), 32'(bus0.done), (c == 6) ? 32'd1 : 32'd0);
      check($sformatf("t1_ready_c%0d", c + 1), 32'(bus0.ready), (c == 6) ? 32'd1 : 32'd0);
    end

    // Test 2: HOLD=1 exit, then back-to-back enter on the done cycle
    wait_ready(1);
    req(1, 1'b0, 1'b1);
    check("t2_ab_c1", 32'(dut_ab[1]), 32'd2);
    @(negedge clk);
    check("t2_ab_c2", 32'(dut_ab[1]), 32'd3);
    @(negedge clk);
    check("t2_ab_c3", 32'(dut_ab[1]), 32'd1);
    @(negedge clk);
    check("t2_ab_c4", 32'(dut_ab[1]), 32'd0);
    check("t2_done_c4", 32'(bus1.done), 32'd1);
    drive(1, 1'b1, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, 1'b0);
    check("t2_b2b_ab", 32'(dut_ab[1]), 32'd1);
    wait_ready(1);

    // Test 3: both starts together -> enter; exit during PH2 ignored
    wait_ready(0);
    #1 d0 = done_cnt[0];
    req(0, 1'b1, 1'b1);
    check("t3_both_enter_ab", 32'(dut_ab[0]), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("t3_ph2_ab", 32'(dut_ab[0]), 32'd3);
    drive(0, 1'b0, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0);
    wait_ready(0);
    repeat (8) @(negedge clk);
    #1 check("t3_single_done", 32'(done_cnt[0] - d0), 32'd1);

    // Test 4: asynchronous reset during PH2
    req(0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("t4_ph2_ab", 32'(dut_ab[0]), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("t4_rst_ab", 32'(dut_ab[0]), 32'd0);
    check("t4_rst_ready", 32'(bus0.ready), 32'd1);
    check("t4_rst_occ", 32'(bus0.occupancy), 32'd0);
    check("t4_rst_done", 32'(bus0.done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 d0 = done_cnt[0];
    repeat (8) @(negedge clk);
    #1 check("t4_no_done_after_abort", 32'(done_cnt[0] - d0), 32'd0);

    // Test 6: random sequences through the lot-side detector
    for (int s = 0; s < 16; s++) begin
      bit d;
      d = 1'($urandom_range(0, 1));
      wait_ready(0);
      req(0, !d, d);
    end
    wait_ready(0);
    repeat (4) @(negedge clk);
    check("t6_enter_pulses", 32'(det_enter), 32'(n_enter[0]));
    check("t6_exit_pulses", 32'(det_exit), 32'(n_exit[0]));
    check("t6_spurious", 32'(det_spur), 32'd0);

    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
